// File: rtl/vid_sync_gen.sv
// Video timing generator: pixel-phase counter plus h/v raster counters,
// decoded into registered display enables, syncs and a position bus.
module vid_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CLK_DIV  = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  pc_ena,
    output logic        hde_out,
    output logic        vde_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic [47:0] HV_triggers_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Segment boundaries pre-sized to the 12-bit counter width
    localparam logic [11:0] H_LAST      = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_DE_END    = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG  = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] H_SYNC_END  = 12'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [11:0] V_LAST      = 12'(V_TOTAL - 1);
    localparam logic [11:0] V_DE_END    = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_BEG  = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] V_SYNC_END  = 12'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [3:0]  PC_LAST     = 4'(CLK_DIV - 1);
    localparam logic        HS_ON       = 1'(HS_POL);
    localparam logic        VS_ON       = 1'(VS_POL);

    logic [11:0] h_cnt;
    logic [11:0] v_cnt;
    logic        tick;

    logic        hde_d;
    logic        vde_d;
    logic        hs_d;
    logic        vs_d;
    logic [47:0] hv_d;

    assign tick = (pc_ena == 4'd0);

    // Decode of the current raster position; registered on the tick
    always_comb begin
        hde_d = (h_cnt < H_DE_END);
        vde_d = (v_cnt < V_DE_END);
        hs_d  = ((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END)) ? HS_ON : ~HS_ON;
        // vs depends only on v_cnt, which moves only at h wrap, so its
        // edges line up with h = 0 on the outputs
        vs_d  = ((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END)) ? VS_ON : ~VS_ON;
        hv_d  = {22'd0, (h_cnt == 12'd0) && (v_cnt == 12'd0), (h_cnt == 12'd0), v_cnt, h_cnt};
    end

    // Phase counter, raster counters and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_ena          <= 4'd0;
            h_cnt           <= 12'd0;
            v_cnt           <= 12'd0;
            hde_out         <= 1'b0;
            vde_out         <= 1'b0;
            hs_out          <= ~HS_ON;
            vs_out          <= ~VS_ON;
            HV_triggers_out <= 48'd0;
        end else begin
            pc_ena <= (pc_ena == PC_LAST) ? 4'd0 : pc_ena + 4'd1;
            if (tick) begin
                hde_out         <= hde_d;
                vde_out         <= vde_d;
                hs_out          <= hs_d;
                vs_out          <= vs_d;
                HV_triggers_out <= hv_d;
                if (h_cnt == H_LAST) begin
                    h_cnt <= 12'd0;
                    v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
                end else begin
                    h_cnt <= h_cnt + 12'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vid_sync_gen.sv
// Bench for vid_sync_gen: two instances (CLK_DIV 2 and 1) on a small raster,
// compared every clock against a tick-count model of the raster timing.
module tb_vid_sync_gen;

    localparam int HT = 16;
    localparam int VT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  pc_a, pc_b;
    logic        hde_a, vde_a, hs_a, vs_a;
    logic        hde_b, vde_b, hs_b, vs_b;
    logic [47:0] hv_a, hv_b;

    int chk_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;
    int e_a     = 0;
    int e_b     = 0;
    int prev_a  = -1;
    int prev_b  = -1;
    logic last_a = 1'b0;
    logic last_b = 1'b0;

    always #5 clk = ~clk;

    vid_sync_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HS_POL(0), .VS_POL(0), .CLK_DIV(2)
    ) u_div2 (
        .clk(clk), .reset(rst), .pc_ena(pc_a),
        .hde_out(hde_a), .vde_out(vde_a), .hs_out(hs_a), .vs_out(vs_a),
        .HV_triggers_out(hv_a)
    );

    vid_sync_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .HS_POL(0), .VS_POL(0), .CLK_DIV(1)
    ) u_div1 (
        .clk(clk), .reset(rst), .pc_ena(pc_b),
        .hde_out(hde_b), .vde_out(vde_b), .hs_out(hs_b), .vs_out(vs_b),
        .HV_triggers_out(hv_b)
    );

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Expected outputs after e clean edges since reset: ticks seen so far is
    // ceil(e/div); the outputs show the raster position of the last tick.
    task automatic model(input int e, input int div, output logic [3:0] pc,
                         output logic hde, output logic vde, output logic hs,
                         output logic vs, output logic [47:0] hv);
        int t, q, h, v;
        pc = 4'(e % div);
        t  = (e + div - 1) / div;
        if (t == 0) begin
            hde = 0; vde = 0; hs = 1; vs = 1; hv = '0;
        end else begin
            q   = (t - 1) % (HT * VT);
            h   = q % HT;
            v   = q / HT;
            hde = (h < 8);
            vde = (v < 4);
            hs  = !(h >= 10 && h <= 12);
            vs  = !(v >= 5 && v <= 6);
            hv  = {22'd0, 1'(h == 0 && v == 0), 1'(h == 0), 12'(v), 12'(h)};
        end
    endtask

    // One clock with reset level r, then full comparison of both instances
    task automatic step(input logic r);
        logic [3:0]  pc;
        logic        hde, vde, hs, vs;
        logic [47:0] hv;
        rst = r;
        @(posedge clk);
        cyc++;
        e_a = r ? 0 : e_a + 1;
        e_b = r ? 0 : e_b + 1;
        @(negedge clk);
        model(e_a, 2, pc, hde, vde, hs, vs, hv);
        check("a_pc",  48'(pc_a), 48'(pc));
        check("a_hde", 48'(hde_a), 48'(hde));
        check("a_vde", 48'(vde_a), 48'(vde));
        check("a_hs",  48'(hs_a), 48'(hs));
        check("a_vs",  48'(vs_a), 48'(vs));
        check("a_hv",  hv_a, hv);
        model(e_b, 1, pc, hde, vde, hs, vs, hv);
        check("b_pc",  48'(pc_b), 48'(pc));
        check("b_hde", 48'(hde_b), 48'(hde));
        check("b_vde", 48'(vde_b), 48'(vde));
        check("b_hs",  48'(hs_b), 48'(hs));
        check("b_vs",  48'(vs_b), 48'(vs));
        check("b_hv",  hv_b, hv);
        // Frame period from observed frame_start rising edges
        if (r) begin
            prev_a = -1; prev_b = -1;
        end else begin
            if (hv_a[25] && !last_a) begin
                if (prev_a >= 0) check("a_frame_period", 48'(cyc - prev_a), 48'd256);
                prev_a = cyc;
            end
            if (hv_b[25] && !last_b) begin
                if (prev_b >= 0) check("b_frame_period", 48'(cyc - prev_b), 48'd128);
                prev_b = cyc;
            end
        end
        last_a = hv_a[25];
        last_b = hv_b[25];
    endtask

    initial begin
        logic [3:0]  pc;
        logic        hde, vde, hs, vs;
        logic [47:0] hv;
        bit          hit;

        // Reset and release; first tick decodes (0,0)
        step(1'b1);
        step(1'b1);
        check("rst_hv", hv_a, 48'd0);
        check("rst_hs", 48'(hs_a), 48'd1);
        step(1'b0);
        check("first_hv", hv_a, 48'h3000000);
        check("first_hde", 48'({hde_a, vde_a, hs_a, vs_a}), 48'hf);
        step(1'b0);
        check("first_pc", 48'(pc_a), 48'd0);

        // Three full frames of the slow instance covers wrap and periods
        for (int i = 0; i < 3 * 256; i++) step(1'b0);

        // Mid-frame reset once the slow instance shows h=5, v=2
        hit = 0;
        for (int i = 0; i < 600 && !hit; i++) begin
            model(e_a, 2, pc, hde, vde, hs, vs, hv);
            if (hv[11:0] == 12'd5 && hv[23:12] == 12'd2) hit = 1;
            else step(1'b0);
        end
        check("midrst_reached", 48'(hit), 48'd1);
        step(1'b1);
        check("midrst_hv", hv_a, 48'd0);
        check("midrst_pc", 48'(pc_a), 48'd0);
        for (int i = 0; i < 300; i++) step(1'b0);

        // Random run lengths separated by random-length reset pulses
        for (int s = 0; s < 20; s++) begin
            int len;
            int rl;
            len = int'($urandom_range(1, 700));
            rl  = int'($urandom_range(1, 3));
            for (int i = 0; i < rl; i++) step(1'b1);
            for (int i = 0; i < len; i++) step(1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
